// File: rtl/ram_loader_pkg.sv
// Shared constants for the word-RAM port controller: FSM state encoding,
// read-response latency and checksum width.
package ram_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WR       = 3'd1;
  localparam state_t ST_RD_ISSUE = 3'd2;
  localparam state_t ST_RD_CAP   = 3'd3;
  localparam state_t ST_RSP      = 3'd4;

  // Edges from request accept to rd_rsp_valid rising, accept edge included.
  localparam int RSP_LAT = 3;
  localparam int CSUM_W  = 16;

endpackage

// File: rtl/ram_loader.sv
// Front-end port controller for the word RAM: byte-stream loader plus 32-bit read port.
// Optional byte checksum is built only when LOADER_CSUM_EN is defined.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_stop,
  input  logic [DEPTH-1:0]  load_base,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  input  logic              rd_req_valid,
  input  logic [DEPTH-1:0]  rd_req_addr,
  output logic              rd_req_ready,
  output logic              rd_rsp_valid,
  output logic [31:0]       rd_rsp_data,
  input  logic              rd_rsp_ready,
  output logic [DEPTH-1:0]  load_ptr,
  output logic              load_active,
  output logic              wrapped,
  output logic [CSUM_W-1:0] csum,
  output logic              ram_we,
  output logic [WIDTH-1:0]  ram_data,
  output logic [DEPTH-1:0]  ram_addr,
  input  logic [31:0]       ram_q
);

  // state | meaning
  // IDLE     | port free; accepts a read (priority) or a stream byte
  // WR       | ram_we pulse is on the RAM pins; drop it next edge
  // RD_ISSUE | RAM samples the read address with we=0
  // RD_CAP   | registered RAM output is valid; capture it
  // RSP      | response held until the consumer takes it

  state_t             r_state;
  logic               r_ram_we;
  logic [WIDTH-1:0]   r_ram_data;
  logic [DEPTH-1:0]   r_ram_addr;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_data;
  logic [DEPTH-1:0]   r_load_ptr;
  logic               r_load_active;
  logic               r_wrapped;

  logic w_idle;
  logic w_in_ready;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_idle     = (r_state == ST_IDLE);
  // A pending read or a base reload blocks the byte so the byte never lands at a stale pointer.
  assign w_in_ready = w_idle & r_load_active & ~rd_req_valid & ~load_start;
  assign w_rd_acc   = w_idle & rd_req_valid;
  assign w_wr_acc   = in_valid & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ram_we    <= 1'b0;
      r_ram_data  <= '0;
      r_ram_addr  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rd_acc) begin
            r_ram_addr <= rd_req_addr;
            r_ram_we   <= 1'b0;
            r_state    <= ST_RD_ISSUE;
          end else if (w_wr_acc) begin
            r_ram_we   <= 1'b1;
            r_ram_data <= in_data;
            r_ram_addr <= r_load_ptr;
            r_state    <= ST_WR;
          end
        end
        ST_WR: begin
          r_ram_we <= 1'b0;
          r_state  <= ST_IDLE;
        end
        ST_RD_ISSUE: r_state <= ST_RD_CAP;
        ST_RD_CAP: begin
          r_rsp_data  <= ram_q;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RSP;
        end
        ST_RSP: begin
          if (rd_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_ram_we <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Load session registers run independently of the FSM so a reload never aborts an op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_ptr    <= '0;
      r_load_active <= 1'b0;
      r_wrapped     <= 1'b0;
    end else if (load_start) begin
      r_load_ptr    <= load_base;
      r_load_active <= 1'b1;
      r_wrapped     <= 1'b0;
    end else begin
      if (load_stop) r_load_active <= 1'b0;
      if (w_wr_acc) begin
        r_load_ptr <= r_load_ptr + DEPTH'(1);
        if (&r_load_ptr) r_wrapped <= 1'b1;
      end
    end
  end

`ifdef LOADER_CSUM_EN
  logic [CSUM_W-1:0] r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (load_start) begin
      r_csum <= '0;
    end else if (w_wr_acc) begin
      r_csum <= r_csum + CSUM_W'(in_data);
    end
  end

  assign csum = r_csum;
`else
  assign csum = '0;
`endif

  assign in_ready     = w_in_ready;
  assign rd_req_ready = w_idle;
  assign rd_rsp_valid = r_rsp_valid;
  assign rd_rsp_data  = r_rsp_data;
  assign load_ptr     = r_load_ptr;
  assign load_active  = r_load_active;
  assign wrapped      = r_wrapped;
  assign ram_we       = r_ram_we;
  assign ram_data     = r_ram_data;
  assign ram_addr     = r_ram_addr;

endmodule
